seq_alu: RTL and testbench

- Parametrised, registered ALU for the multi-cycle CPU datapath.
- Covers the base operation set: add, sub, shift-left, or, and, unsigned/signed compare, xor.
- Adds logical/arithmetic right shift, iterative unsigned multiply (low/high word) and unsigned divide/remainder, plus carry/overflow/error flags.
- The controller issues an operation with start and waits for done; the result is held stable for the write-back state.

---
 rtl/seq_alu_pkg.sv | 44 ++++
 rtl/seq_alu_muldiv.sv | 76 +++++++
 rtl/seq_alu.sv | 198 +++++++++++++++++++
 tb/tb_seq_alu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu_pkg : op codes, FSM state encoding and op-class helpers for seq_alu
// Revision    : 1.0
// ---------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULLO = 4'd10;
  localparam logic [3:0] OP_MULHI = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op >= OP_MULLO) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHI and REMU take the upper half of the shared accumulator
  function automatic logic selects_high(input logic [3:0] op);
    return (op == OP_MULHI) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu_muldiv : iterative shift-add multiplier / restoring divider
// Revision       : 1.0
// ---------------------------------------------------------------------------
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode_div,
  input  logic             step,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_operand;
  logic             r_div;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // hi holds partial product / partial remainder; lo holds multiplier / quotient
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_operand};
    hi_next = r_hi;
    lo_next = r_lo;
    if (r_div) begin
      if (!w_trial[WIDTH]) begin
        hi_next = w_trial[WIDTH-1:0];
        lo_next = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = w_shift[WIDTH-1:0];
        lo_next = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {w_sum, r_lo[WIDTH-1:1]};
    end
  end

  assign last = step && (r_count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_div     <= 1'b0;
      r_count   <= '0;
    end else if (load) begin
      r_hi      <= '0;
      r_lo      <= mode_div ? opa : opb;
      r_operand <= mode_div ? opb : opa;
      r_div     <= mode_div;
      r_count   <= CW'(WIDTH);
    end else if (step && (r_count != '0)) begin
      r_hi      <= hi_next;
      r_lo      <= lo_next;
      r_count   <= r_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu  : registered multi-cycle ALU with start/done handshake and flags
// Revision : 1.0
// ---------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_err;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_bneg;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic             w_alu_err;

  logic             w_md_load;
  logic             w_md_step;
  logic             w_md_last;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_word;

  logic             w_we;
  logic [WIDTH-1:0] w_we_result;
  logic             w_we_carry;
  logic             w_we_ovf;
  logic             w_we_err;

  // Single-cycle ops, plus the divide-by-zero shortcut for DIVU/REMU
  always_comb begin
    w_shamt     = inputA[SHW-1:0];
    w_sum       = {1'b0, inputA} + {1'b0, inputB};
    w_diff      = {1'b0, inputA} - {1'b0, inputB};
    w_bneg      = ~inputB + WIDTH'(1);
    w_alu       = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    w_alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu       = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu       = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
        w_alu_ovf   = (inputA[WIDTH-1] == w_bneg[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_SLL:   w_alu = inputB << w_shamt;
      OP_OR:    w_alu = inputA | inputB;
      OP_AND:   w_alu = inputA & inputB;
      OP_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
      OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
      OP_XOR:   w_alu = inputA ^ inputB;
      OP_SRL:   w_alu = inputB >> w_shamt;
      OP_SRA:   w_alu = $signed(inputB) >>> w_shamt;
      OP_MULLO: w_alu = '0;
      OP_MULHI: w_alu = '0;
      OP_DIVU: begin
        w_alu     = '1;
        w_alu_err = 1'b1;
      end
      OP_REMU: begin
        w_alu     = inputA;
        w_alu_err = 1'b1;
      end
      default: begin
        w_alu     = '0;
        w_alu_err = 1'b1;
      end
    endcase
  end

  assign w_md_word = selects_high(r_op) ? w_md_hi : w_md_lo;

  always_comb begin
    w_state_next = r_state;
    w_md_load    = 1'b0;
    w_md_step    = 1'b0;
    w_we         = 1'b0;
    w_we_result  = w_alu;
    w_we_carry   = w_alu_carry;
    w_we_ovf     = w_alu_ovf;
    w_we_err     = w_alu_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_multicycle(op) && !(is_div_op(op) && (inputB == '0))) begin
            w_md_load    = 1'b1;
            w_state_next = is_div_op(op) ? ST_DIV : ST_MUL;
          end else begin
            w_we         = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        w_md_step = 1'b1;
        if (w_md_last) begin
          w_we         = 1'b1;
          w_we_result  = w_md_word;
          w_we_carry   = 1'b0;
          w_we_ovf     = 1'b0;
          w_we_err     = 1'b0;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op       <= OP_ADD;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_op <= op;
      end
      if (w_we) begin
        r_result   <= w_we_result;
        r_carry    <= w_we_carry;
        r_overflow <= w_we_ovf;
        r_err      <= w_we_err;
      end
    end
  end

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (CLK),
    .rst      (RST),
    .load     (w_md_load),
    .mode_div (is_div_op(op)),
    .step     (w_md_step),
    .opa      (inputA),
    .opb      (inputB),
    .last     (w_md_last),
    .lo_next  (w_md_lo),
    .hi_next  (w_md_hi)
  );

  assign busy     = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign zero     = (r_result == '0);
  assign sign     = r_result[WIDTH-1];
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_alu : directed and random checks of seq_alu against a reference model
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [3:0]  op;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        sign;
  logic        carry;
  logic        overflow;
  logic        err;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .CLK      (clk),
    .RST      (RST),
    .start    (start),
    .op       (op),
    .inputA   (inputA),
    .inputB   (inputB),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .sign     (sign),
    .carry    (carry),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic e);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned p;
    longint          s;
    logic [31:0]     bn;
    r = 32'd0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      4'd0: begin
        p = ua + ub; r = p[31:0]; c = (p > 64'hFFFF_FFFF);
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a < b); bn = -b;
        v = (a[31] == bn[31]) && (r[31] != a[31]);
      end
      4'd2:  r = b << a[4:0];
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = (a < b) ? 32'd1 : 32'd0;
      4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  r = a ^ b;
      4'd8:  r = b >> a[4:0];
      4'd9:  r = $signed(b) >>> a[4:0];
      4'd10: begin p = ua * ub; r = p[31:0]; end
      4'd11: begin p = ua * ub; r = p[63:32]; end
      4'd12: if (b == 0) begin r = 32'hFFFF_FFFF; e = 1'b1; end else r = a / b;
      4'd13: if (b == 0) begin r = a; e = 1'b1; end else r = a % b;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [3:0] o, input logic [31:0] b);
    if (o == 4'd10 || o == 4'd11) return 33;
    if ((o == 4'd12 || o == 4'd13) && b != 0) return 33;
    return 1;
  endfunction

  // Issue one op from IDLE, wait for done (bounded), check everything, return to IDLE.
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit disturb, input string tag);
    logic [31:0] er;
    logic        ec, ev, ee;
    int          lat;
    model(o, a, b, er, ec, ev, ee);
    op = o; inputA = a; inputB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 80) begin
      if (disturb) begin
        inputA = $urandom; inputB = $urandom; op = 4'($urandom); start = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_latency(o, b)));
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_flags"}, 64'({zero, sign, carry, overflow, err}),
        64'({(er == 32'd0), er[31], ec, ev, ee}));
    @(posedge clk); #1;
    chk({tag, "_post"}, 64'({done, busy, result}), 64'({2'b00, er}));
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;
    RST = 1'b1; start = 1'b0; op = 4'd0; inputA = '0; inputB = '0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    chk("reset_out", 64'({busy, done, result, zero, sign, carry, overflow, err}),
        64'({2'b00, 32'h0, 5'b10000}));

    run(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, "add_wrap");
    chk("add_wrap_const", 64'({result, zero, carry, overflow}), 64'({32'h0, 3'b110}));
    run(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, "add_ovf");
    chk("add_ovf_const", 64'({result, sign, overflow}), 64'({32'h8000_0000, 2'b11}));
    run(4'd1, 32'h5, 32'h7, 1'b0, "sub_borrow");
    run(4'd6, 32'hFFFF_FFFE, 32'h1, 1'b0, "slt");
    chk("slt_const", 64'(result), 64'd1);
    run(4'd5, 32'hFFFF_FFFE, 32'h1, 1'b0, "sltu");
    chk("sltu_const", 64'(result), 64'd0);
    run(4'd9, 32'd4, 32'h8000_0000, 1'b0, "sra");
    chk("sra_const", 64'(result), 64'hF800_0000);
    run(4'd2, 32'd33, 32'h1, 1'b0, "sll_mask");
    chk("sll_mask_const", 64'(result), 64'd2);
    run(4'd8, 32'd4, 32'h8000_0000, 1'b0, "srl");

    run(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mullo");
    chk("mullo_const", 64'(result), 64'h1);
    run(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhi");
    chk("mulhi_const", 64'(result), 64'hFFFF_FFFE);
    run(4'd10, 32'd123457, 32'd98765, 1'b1, "mullo_disturb");

    run(4'd12, 32'd100, 32'd7, 1'b0, "divu");
    chk("divu_const", 64'(result), 64'd14);
    run(4'd13, 32'd100, 32'd7, 1'b0, "remu");
    chk("remu_const", 64'(result), 64'd2);
    run(4'd12, 32'd5, 32'd0, 1'b0, "divu_by0");
    chk("divu_by0_const", 64'({result, err}), 64'({32'hFFFF_FFFF, 1'b1}));
    run(4'd13, 32'd5, 32'd0, 1'b0, "remu_by0");
    chk("remu_by0_const", 64'({result, err}), 64'({32'd5, 1'b1}));

    // abort a divide with reset in its tenth busy cycle
    op = 4'd12; inputA = 32'd1000; inputB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_busy_before", 64'(busy), 64'd1);
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    chk("rst_abort_out", 64'({busy, done, result, zero, sign, carry, overflow, err}),
        64'({2'b00, 32'h0, 5'b10000}));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    run(4'd0, 32'd20, 32'd22, 1'b0, "add_after_rst");

    run(4'd14, 32'd9, 32'd9, 1'b0, "rsv14");
    chk("rsv14_const", 64'({result, zero, err}), 64'({32'h0, 2'b11}));
    run(4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, "xor_clr_err");
    chk("xor_clr_err_const", 64'(err), 64'd0);
    run(4'd15, 32'd1, 32'd2, 1'b0, "rsv15");

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run(ro, ra, rb, 1'b0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
